// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared screen geometry, field widths, EOL code and parser states
package vga_pkg;

    localparam int N_COL = 160;
    localparam int N_ROW = 64;
    localparam int COL_W = 8;
    localparam int ROW_W = 6;
    localparam int CHR_W = 7;

    localparam logic [7:0] EOL_CODE = 8'h0A;

    typedef enum logic [2:0] {
        S_COL    = 3'd0,
        S_ROW    = 3'd1,
        S_CHAR   = 3'd2,
        S_EOL    = 3'd3,
        S_RESYNC = 3'd4
    } state_t;

endpackage

// File: rtl/rx_edge_det.sv
// rtl/rx_edge_det.sv - rising-edge detector turning the UART byte-valid level into a byte event
module rx_edge_det (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic wr_i,
    output logic evt_o
);

    logic wr_q;

    // Delayed copy of wr_i; resets high so a level already high at reset release is not an event
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_q <= 1'b1;
        end else begin
            wr_q <= wr_i;
        end
    end

    assign evt_o = wr_i & ~wr_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - col/row/char/EOL frame parser feeding the text screen buffer (optional PARSER_TIMEOUT_EN)
module uart_cmd_parser
    import vga_pkg::*;
#(
    parameter int N_COL          = vga_pkg::N_COL,
    parameter int N_ROW          = vga_pkg::N_ROW,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             wr_i,
    input  logic [7:0]       data_i,
    output logic             wr_en_o,
    output logic [COL_W-1:0] col_w_o,
    output logic [ROW_W-1:0] row_w_o,
    output logic [CHR_W-1:0] din_o,
    output logic             frame_err_o,
    output logic [7:0]       err_cnt_o
);

    localparam logic [8:0] NCOL9 = 9'(N_COL);

    // Reject configurations the fixed port widths cannot represent
    if (TIMEOUT_CYCLES < 2 || N_ROW > (1 << ROW_W) || N_COL > 256) begin : g_bad_cfg
        $error("uart_cmd_parser: unsupported N_COL/N_ROW/TIMEOUT_CYCLES");
    end

    logic             byte_evt;
    state_t           state, state_nxt;
    logic [COL_W-1:0] col_nxt;
    logic [ROW_W-1:0] row_nxt;
    logic [CHR_W-1:0] din_nxt;
    logic             wr_nxt;
    logic             err_nxt;
    logic             tmo_hit;

    rx_edge_det u_edge_det (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .wr_i   (wr_i),
        .evt_o  (byte_evt)
    );

`ifdef PARSER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;
    logic        tmo_run;

    assign tmo_run = (state == S_ROW) || (state == S_CHAR) || (state == S_EOL);
    assign tmo_hit = tmo_run && (tmo_cnt == TMO_LAST);

    // Inter-byte idle counter: cleared by bytes and on returning to S_COL, runs mid-frame only
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tmo_cnt <= '0;
        end else if (byte_evt || state_nxt == S_COL || !tmo_run) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // State and output registers; every update lands one cycle after its byte event
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= S_COL;
            col_w_o     <= '0;
            row_w_o     <= '0;
            din_o       <= '0;
            wr_en_o     <= 1'b0;
            frame_err_o <= 1'b0;
            err_cnt_o   <= '0;
        end else begin
            state       <= state_nxt;
            col_w_o     <= col_nxt;
            row_w_o     <= row_nxt;
            din_o       <= din_nxt;
            wr_en_o     <= wr_nxt;
            frame_err_o <= err_nxt;
            if (err_nxt && err_cnt_o != 8'hFF) begin
                err_cnt_o <= err_cnt_o + 8'd1;
            end
        end
    end

    // Frame decode; a byte event takes priority over a simultaneous timeout
    always_comb begin
        state_nxt = state;
        col_nxt   = col_w_o;
        row_nxt   = row_w_o;
        din_nxt   = din_o;
        wr_nxt    = 1'b0;
        err_nxt   = 1'b0;
        if (byte_evt) begin
            case (state)
                S_COL: begin
                    if ({1'b0, data_i} >= NCOL9) begin
                        col_nxt = data_i - NCOL9[7:0];
                    end else begin
                        col_nxt = data_i;
                    end
                    state_nxt = S_ROW;
                end
                S_ROW: begin
                    row_nxt   = data_i[ROW_W-1:0];
                    state_nxt = S_CHAR;
                end
                S_CHAR: begin
                    if (data_i[7]) begin
                        err_nxt = 1'b1;
                    end else begin
                        din_nxt = data_i[CHR_W-1:0];
                        wr_nxt  = 1'b1;
                    end
                    state_nxt = S_EOL;
                end
                S_EOL: begin
                    if (data_i == EOL_CODE) begin
                        state_nxt = S_COL;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = S_RESYNC;
                    end
                end
                S_RESYNC: begin
                    if (data_i == EOL_CODE) begin
                        state_nxt = S_COL;
                    end
                end
                default: state_nxt = S_COL;
            endcase
        end else if (tmo_hit) begin
            err_nxt   = 1'b1;
            state_nxt = S_COL;
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - directed self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;

    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic       wr_i = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       wr_en_o;
    logic [7:0] col_w_o;
    logic [5:0] row_w_o;
    logic [6:0] din_o;
    logic       frame_err_o;
    logic [7:0] err_cnt_o;

    int tests = 0;
    int fails = 0;
    int wr_pulses = 0;
    int err_pulses = 0;
    int exp_err;

    uart_cmd_parser #(
        .N_COL          (160),
        .N_ROW          (64),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .wr_i        (wr_i),
        .data_i      (data_i),
        .wr_en_o     (wr_en_o),
        .col_w_o     (col_w_o),
        .row_w_o     (row_w_o),
        .din_o       (din_o),
        .frame_err_o (frame_err_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Count high cycles of the two pulse outputs, sampled away from the rising edge
    always @(negedge clk_i) begin
        if (wr_en_o)     wr_pulses  <= wr_pulses + 1;
        if (frame_err_o) err_pulses <= err_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        @(negedge clk_i);
        data_i = d;
        wr_i   = 1'b1;
        @(negedge clk_i);
        wr_i   = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        // Reset state
        idle(2);
        check("rst_wr_en", 32'(wr_en_o), 32'h0);
        check("rst_frame_err", 32'(frame_err_o), 32'h0);
        check("rst_col", 32'(col_w_o), 32'h0);
        check("rst_row", 32'(row_w_o), 32'h0);
        check("rst_din", 32'(din_o), 32'h0);
        check("rst_err_cnt", 32'(err_cnt_o), 32'h0);
        rstn_i = 1'b1;
        idle(2);

        // Basic frame 05 03 41 0A
        send_byte(8'h05); send_byte(8'h03); send_byte(8'h41); send_byte(8'h0A);
        idle(1);
        check("f1_wr_pulses", 32'(wr_pulses), 32'd1);
        check("f1_col", 32'(col_w_o), 32'd5);
        check("f1_row", 32'(row_w_o), 32'd3);
        check("f1_din", 32'(din_o), 32'h41);
        check("f1_err_cnt", 32'(err_cnt_o), 32'd0);

        // Column wrap and max row: A5 3F 7E 0A
        send_byte(8'hA5); send_byte(8'h3F); send_byte(8'h7E); send_byte(8'h0A);
        idle(1);
        check("f2_wr_pulses", 32'(wr_pulses), 32'd2);
        check("f2_col", 32'(col_w_o), 32'd5);
        check("f2_row", 32'(row_w_o), 32'd63);
        check("f2_din", 32'(din_o), 32'h7E);

        // Bad char: 01 02 C1 0A then 00 00 20 0A
        send_byte(8'h01); send_byte(8'h02); send_byte(8'hC1); send_byte(8'h0A);
        idle(1);
        check("f3_wr_pulses", 32'(wr_pulses), 32'd2);
        check("f3_err_pulses", 32'(err_pulses), 32'd1);
        check("f3_err_cnt", 32'(err_cnt_o), 32'd1);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h20); send_byte(8'h0A);
        idle(1);
        check("f4_wr_pulses", 32'(wr_pulses), 32'd3);
        check("f4_col", 32'(col_w_o), 32'd0);
        check("f4_row", 32'(row_w_o), 32'd0);
        check("f4_din", 32'(din_o), 32'h20);

        // Missing EOL then resync: 01 02 41 55 33 0A, 07 08 42 0A
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h41);
        idle(1);
        check("f5_wr_pulses", 32'(wr_pulses), 32'd4);
        check("f5_col", 32'(col_w_o), 32'd1);
        check("f5_row", 32'(row_w_o), 32'd2);
        check("f5_din", 32'(din_o), 32'h41);
        send_byte(8'h55); send_byte(8'h33); send_byte(8'h0A);
        idle(1);
        check("f5_err_pulses", 32'(err_pulses), 32'd2);
        check("f5_err_cnt", 32'(err_cnt_o), 32'd2);
        send_byte(8'h07); send_byte(8'h08); send_byte(8'h42); send_byte(8'h0A);
        idle(1);
        check("f6_wr_pulses", 32'(wr_pulses), 32'd5);
        check("f6_col", 32'(col_w_o), 32'd7);
        check("f6_row", 32'(row_w_o), 32'd8);
        check("f6_din", 32'(din_o), 32'h42);
        check("f6_err_pulses", 32'(err_pulses), 32'd2);

        // Idle gap after a column byte
        send_byte(8'h09);
        idle(120);
`ifdef PARSER_TIMEOUT_EN
        exp_err = 3;
        check("tmo_err_pulses", 32'(err_pulses), 32'd3);
        send_byte(8'h02); send_byte(8'h04); send_byte(8'h43); send_byte(8'h0A);
        idle(1);
        check("tmo_col", 32'(col_w_o), 32'd2);
`else
        exp_err = 2;
        check("wait_err_pulses", 32'(err_pulses), 32'd2);
        send_byte(8'h04); send_byte(8'h43); send_byte(8'h0A);
        idle(1);
        check("wait_col", 32'(col_w_o), 32'd9);
`endif
        check("gap_wr_pulses", 32'(wr_pulses), 32'd6);
        check("gap_row", 32'(row_w_o), 32'd4);
        check("gap_din", 32'(din_o), 32'h43);
        check("gap_err_cnt", 32'(err_cnt_o), 32'(exp_err));

        // Reset mid-frame with wr_i held high through release
        send_byte(8'h01); send_byte(8'h02);
        @(negedge clk_i);
        data_i = 8'h41;
        wr_i   = 1'b1;
        rstn_i = 1'b0;
        idle(2);
        rstn_i = 1'b1;
        idle(3);
        check("rst_mid_wr_pulses", 32'(wr_pulses), 32'd6);
        check("rst_mid_err_pulses", 32'(err_pulses), 32'(exp_err));
        check("rst_mid_err_cnt", 32'(err_cnt_o), 32'd0);
        check("rst_mid_col", 32'(col_w_o), 32'd0);
        wr_i = 1'b0;
        idle(1);
        send_byte(8'h03); send_byte(8'h05); send_byte(8'h44); send_byte(8'h0A);
        idle(1);
        check("post_rst_wr_pulses", 32'(wr_pulses), 32'd7);
        check("post_rst_col", 32'(col_w_o), 32'd3);
        check("post_rst_row", 32'(row_w_o), 32'd5);
        check("post_rst_din", 32'(din_o), 32'h44);

        // Error counter saturation after 256 bad frames
        for (int i = 0; i < 256; i++) begin
            send_byte(8'h01); send_byte(8'h02); send_byte(8'hC1); send_byte(8'h0A);
        end
        idle(1);
        check("sat_err_cnt", 32'(err_cnt_o), 32'd255);
        check("sat_err_pulses", 32'(err_pulses), 32'(exp_err + 256));
        check("sat_wr_pulses", 32'(wr_pulses), 32'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter N_COL, default 160, number of text columns.
REQ-002 Parameter N_ROW, default 64, number of text rows.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000, inter-byte timeout in clk_i cycles; must be at least 2.
REQ-004 clk_i  input  1  pixel/system clock (108 MHz domain); one clock; reset is asynchronous and active-low.
REQ-005 rstn_i  input  1  asynchronous active-low reset.
REQ-006 wr_i  input  1  UART byte-valid level; a new byte is signalled by its rising edge.
REQ-007 data_i  input  8  UART received byte; stable while wr_i is high.
REQ-008 wr_en_o  output  1  screen-buffer write strobe, one-cycle pulse.
REQ-009 col_w_o  output  8  column of the tile to write.
REQ-010 row_w_o  output  6  row of the tile to write.
REQ-011 din_o  output  7  ASCII code to write.
REQ-012 frame_err_o  output  1  one-cycle pulse on any framing error.
REQ-013 err_cnt_o  output  8  saturating framing-error count.

Function
REQ-014 Byte event: wr_i high while the internal registered copy wr_q is low; wr_q samples wr_i every cycle.
REQ-015 FSM states: S_COL, S_ROW, S_CHAR, S_EOL, S_RESYNC. Each byte event advances the FSM by exactly one transition.
REQ-016 S_COL: col_w_o <= data_i - N_COL if data_i >= N_COL, else data_i (8-bit result); next state S_ROW.
REQ-017 S_ROW: row_w_o <= data_i[5:0]; next state S_CHAR.
REQ-018 S_CHAR, data_i[7]==0: din_o <= data_i[6:0]; wr_en_o=1 in the cycle after the byte event; next state S_EOL.
REQ-019 S_CHAR, data_i[7]==1: no write; framing error raised; next state S_EOL.
REQ-020 S_EOL, data_i==8'h0A: next state S_COL.
REQ-021 S_EOL, data_i!=8'h0A: framing error raised; next state S_RESYNC.
REQ-022 S_RESYNC: stays until a byte equal to 8'h0A is received, then goes to S_COL; other bytes are discarded without raising further errors.
REQ-023 Framing error: frame_err_o=1 for exactly one cycle, in the cycle after the triggering event; err_cnt_o increments by 1 and saturates at 255.
REQ-024 wr_en_o is high for exactly one cycle per accepted character; col_w_o, row_w_o and din_o hold their values until the next update.
REQ-025 Latency: from byte event to registered output update is exactly 1 cycle, with no backpressure.
REQ-026 A byte event in the same cycle as a timeout expiry is handled as a byte event; the timeout is ignored.

Reset
REQ-027 On rstn_i low, asynchronously: state=S_COL, wr_q=1, outputs wr_en_o/frame_err_o/col_w_o/row_w_o/din_o/err_cnt_o=0, timeout counter=0.
REQ-028 wr_q resetting to 1 suppresses a spurious byte event when wr_i is already high at reset release.
REQ-029 Reset mid-frame discards the partial frame and issues no write.

Configuration
REQ-030 Macro PARSER_TIMEOUT_EN defined: a 16-bit counter clears on every byte event and on entry to S_COL, and counts while in S_ROW, S_CHAR or S_EOL.
REQ-031 With PARSER_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYCLES-1, the FSM returns to S_COL and a framing error is raised.
REQ-032 With PARSER_TIMEOUT_EN defined: S_RESYNC never times out.
REQ-033 Macro PARSER_TIMEOUT_EN undefined: no counter is instantiated, and partial frames wait indefinitely.

Structure
REQ-034 Shared package vga_pkg holds N_COL, N_ROW, the column/row/char widths (8/6/7), the EOL code 8'h0A and the FSM state encoding.
REQ-035 One sub-module, rx_edge_det, implements the wr_i rising-edge detector; the FSM, counter and outputs stay in uart_cmd_parser.

Verification
REQ-036 Bytes 0x05,0x03,0x41,0x0A -> one wr_en_o pulse with col=5, row=3, din=0x41; err_cnt_o=0.
REQ-037 Bytes 0xA5,0x3F,0x7E,0x0A -> write with col=5 (165-160), row=63, din=0x7E.
REQ-038 Bytes 0x01,0x02,0xC1,0x0A -> no write; one frame_err_o pulse; err_cnt_o=1; next frame 0x00,0x00,0x20,0x0A writes normally.
REQ-039 Bytes 0x01,0x02,0x41,0x55,0x33,0x0A, then 0x07,0x08,0x42,0x0A -> write (1,2,0x41); one error; 0x33 discarded; then write (7,8,0x42).
REQ-040 PARSER_TIMEOUT_EN, TIMEOUT_CYCLES=100: byte 0x09, then 100 idle cycles -> frame_err_o pulse, FSM in S_COL; next frame 0x02,0x04,0x43,0x0A writes (2,4,0x43).
REQ-041 Assert rstn_i after bytes 0x01,0x02; hold wr_i high through reset release -> no write, no error; next full frame decodes correctly.
